// File: rtl/maindec_mc_pkg.sv
// Shared types and constants for the multicycle LEGv8 main decoder.
package maindec_mc_pkg;

    localparam int unsigned OP_W    = 11;
    localparam int unsigned STATE_W = 4;

    // FSM states; encodings are visible on the debug port.
    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_IMMEX  = 4'd7,
        S_ALUWB  = 4'd8,
        S_CBR    = 4'd9,
        S_UBR    = 4'd10
    } state_t;

    // Full-width opcodes.
    localparam logic [OP_W-1:0] OP_LDUR = 11'b11111000010;
    localparam logic [OP_W-1:0] OP_STUR = 11'b11111000000;
    localparam logic [OP_W-1:0] OP_ADD  = 11'b10001011000;
    localparam logic [OP_W-1:0] OP_SUB  = 11'b11001011000;
    localparam logic [OP_W-1:0] OP_AND  = 11'b10001010000;
    localparam logic [OP_W-1:0] OP_ORR  = 11'b10101010000;
    localparam logic [OP_W-1:0] OP_ADDS = 11'b10101011000;
    localparam logic [OP_W-1:0] OP_SUBS = 11'b11101011000;

    // Partial opcodes are matched as (op & mask) == pattern.
    localparam logic [OP_W-1:0] OP_IMM_MASK = 11'b11111111110;
    localparam logic [OP_W-1:0] OP_ADDI     = 11'b10010001000;
    localparam logic [OP_W-1:0] OP_SUBI     = 11'b11010001000;
    localparam logic [OP_W-1:0] OP_CB_MASK  = 11'b11111111000;
    localparam logic [OP_W-1:0] OP_CBZ      = 11'b10110100000;
    localparam logic [OP_W-1:0] OP_CBNZ     = 11'b10110101000;
    localparam logic [OP_W-1:0] OP_B_MASK   = 11'b11111100000;
    localparam logic [OP_W-1:0] OP_B        = 11'b00010100000;

    // ALU B operand select.
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BROFF = 2'b11;

    // Operation class handed to aludec.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Raw opcode classification, before parameter enables are applied.
    typedef struct packed {
        logic ldur;
        logic stur;
        logic rtype;
        logic imm;
        logic cbz;
        logic cbnz;
        logic b;
    } op_class_t;

    function automatic logic op_match(input logic [OP_W-1:0] op,
                                      input logic [OP_W-1:0] mask,
                                      input logic [OP_W-1:0] pat);
        return (op & mask) == pat;
    endfunction

    function automatic op_class_t classify_op(input logic [OP_W-1:0] op);
        op_class_t c;
        c.ldur  = (op == OP_LDUR);
        c.stur  = (op == OP_STUR);
        c.rtype = (op == OP_ADD)  || (op == OP_SUB)  || (op == OP_AND) ||
                  (op == OP_ORR)  || (op == OP_ADDS) || (op == OP_SUBS);
        c.imm   = op_match(op, OP_IMM_MASK, OP_ADDI) || op_match(op, OP_IMM_MASK, OP_SUBI);
        c.cbz   = op_match(op, OP_CB_MASK, OP_CBZ);
        c.cbnz  = op_match(op, OP_CB_MASK, OP_CBNZ);
        c.b     = op_match(op, OP_B_MASK, OP_B);
        return c;
    endfunction

endpackage

// File: rtl/maindec_mc_mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready and flags a timeout.
module mem_wait_timer #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned CNT_W_RAW = $clog2(WAIT_MAX + 1);
    localparam int unsigned CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    // The current waiting cycle is number count_q+1, so the limit is hit at WAIT_MAX-1.
    localparam logic [CNT_W-1:0] LAST = (WAIT_MAX == 0) ? '0 : CNT_W'(WAIT_MAX - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins over increment.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_en) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (WAIT_MAX != 0) && count_en && (count_q == LAST);

endmodule

// File: rtl/maindec_mc.sv
// Multicycle LEGv8 main control FSM with memory-wait timeout.
module maindec_mc
    import maindec_mc_pkg::*;
#(
    parameter bit          IMM_EN   = 1'b1,
    parameter bit          BR_EN    = 1'b1,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] Op,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        IorD,
    output logic        PCSrc,
    output logic        Reg2Loc,
    output logic        ALUSrcA,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic        instr_done,
    output logic        illegal,
    output logic        mem_err,
    output logic [3:0]  state
);

    state_t    state_q;
    state_t    state_d;
    logic      is_cbnz_q;
    logic      is_cbnz_d;

    op_class_t cls;
    logic      dec_mem;
    logic      dec_alu;
    logic      dec_imm;
    logic      dec_cb;
    logic      dec_b;
    logic      dec_legal;

    logic      wait_en;
    logic      wait_clear;
    logic      timeout;

    logic      pc_write_c;
    logic      ir_write_c;
    logic      iord_c;
    logic      pc_src_c;
    logic      reg2loc_c;
    logic      alu_src_a_c;
    logic      memtoreg_c;
    logic      reg_write_c;
    logic      mem_read_c;
    logic      mem_write_c;
    logic [1:0] alu_src_b_c;
    logic [1:0] alu_op_c;
    logic      instr_done_c;
    logic      illegal_c;
    logic      mem_err_c;

    // Opcode decode with optional instruction groups masked by parameters.
    always_comb begin
        cls       = classify_op(Op);
        dec_mem   = cls.ldur | cls.stur;
        dec_alu   = cls.rtype;
        dec_imm   = IMM_EN & cls.imm;
        dec_cb    = cls.cbz | (BR_EN & cls.cbnz);
        dec_b     = BR_EN & cls.b;
        dec_legal = dec_mem | dec_alu | dec_imm | dec_cb | dec_b;
    end

    // Memory wait tracking: only states that block on mem_ready count.
    assign wait_en = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR))
                     && !mem_ready;
    assign wait_clear = (state_d != state_q) || timeout;

    mem_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait (
        .clk      (clk),
        .reset    (reset),
        .clear    (wait_clear),
        .count_en (wait_en),
        .expired  (timeout)
    );

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        is_cbnz_d = is_cbnz_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                is_cbnz_d = BR_EN & cls.cbnz;
                if (dec_mem) begin
                    state_d = S_MEMADR;
                end else if (dec_alu) begin
                    state_d = S_EXEC;
                end else if (dec_imm) begin
                    state_d = S_IMMEX;
                end else if (dec_cb) begin
                    state_d = S_CBR;
                end else if (dec_b) begin
                    state_d = S_UBR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMADR: state_d = cls.stur ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (timeout) begin
                    state_d = S_FETCH;
                end
            end
            S_MEMWR: begin
                if (mem_ready || timeout) begin
                    state_d = S_FETCH;
                end
            end
            S_MEMWB:  state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_IMMEX:  state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_CBR:    state_d = S_FETCH;
            S_UBR:    state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // State and branch-sense registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            is_cbnz_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_cbnz_q <= is_cbnz_d;
        end
    end

    // Per-state control outputs.
    always_comb begin
        pc_write_c   = 1'b0;
        ir_write_c   = 1'b0;
        iord_c       = 1'b0;
        pc_src_c     = 1'b0;
        reg2loc_c    = 1'b0;
        alu_src_a_c  = 1'b0;
        memtoreg_c   = 1'b0;
        reg_write_c  = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        alu_src_b_c  = SRCB_REG;
        alu_op_c     = ALUOP_ADD;
        instr_done_c = 1'b0;
        illegal_c    = 1'b0;
        mem_err_c    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_c  = 1'b1;
                alu_src_b_c = SRCB_FOUR;
                alu_op_c    = ALUOP_ADD;
                ir_write_c  = mem_ready;
                pc_write_c  = mem_ready;
                mem_err_c   = timeout;
            end
            S_DECODE: begin
                alu_src_b_c  = SRCB_BROFF;
                alu_op_c     = ALUOP_ADD;
                // Second read port must see Rt for stores and compare-branches.
                reg2loc_c    = cls.stur | cls.cbz | cls.cbnz;
                illegal_c    = ~dec_legal;
                instr_done_c = ~dec_legal;
            end
            S_MEMADR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = SRCB_IMM;
                alu_op_c    = ALUOP_ADD;
            end
            S_MEMRD: begin
                iord_c     = 1'b1;
                mem_read_c = 1'b1;
                mem_err_c  = timeout;
            end
            S_MEMWB: begin
                reg_write_c  = 1'b1;
                memtoreg_c   = 1'b1;
                instr_done_c = 1'b1;
            end
            S_MEMWR: begin
                iord_c       = 1'b1;
                mem_write_c  = 1'b1;
                reg2loc_c    = 1'b1;
                instr_done_c = mem_ready;
                mem_err_c    = timeout;
            end
            S_EXEC: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = SRCB_REG;
                alu_op_c    = ALUOP_FUNCT;
            end
            S_IMMEX: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = SRCB_IMM;
                alu_op_c    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_write_c  = 1'b1;
                instr_done_c = 1'b1;
            end
            S_CBR: begin
                alu_src_a_c  = 1'b1;
                reg2loc_c    = 1'b1;
                alu_op_c     = ALUOP_PASSB;
                pc_src_c     = 1'b1;
                pc_write_c   = Zero ^ is_cbnz_q;
                instr_done_c = 1'b1;
            end
            S_UBR: begin
                pc_src_c     = 1'b1;
                pc_write_c   = 1'b1;
                instr_done_c = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Force every output low while reset is asserted.
    assign PCWrite    = ~reset & pc_write_c;
    assign IRWrite    = ~reset & ir_write_c;
    assign IorD       = ~reset & iord_c;
    assign PCSrc      = ~reset & pc_src_c;
    assign Reg2Loc    = ~reset & reg2loc_c;
    assign ALUSrcA    = ~reset & alu_src_a_c;
    assign MemtoReg   = ~reset & memtoreg_c;
    assign RegWrite   = ~reset & reg_write_c;
    assign MemRead    = ~reset & mem_read_c;
    assign MemWrite   = ~reset & mem_write_c;
    assign ALUSrcB    = reset ? 2'b00 : alu_src_b_c;
    assign ALUOp      = reset ? 2'b00 : alu_op_c;
    assign instr_done = ~reset & instr_done_c;
    assign illegal    = ~reset & illegal_c;
    assign mem_err    = ~reset & mem_err_c;
    assign state      = reset ? 4'd0 : 4'(state_q);

endmodule

// File: tb/tb_maindec_mc.sv
// Directed bench for maindec_mc: default, branch-disabled and short-timeout builds.
module tb_maindec_mc;

    // Control bit positions inside the observed vector.
    localparam logic [12:0] PCW  = 13'h1000;
    localparam logic [12:0] IRW  = 13'h0800;
    localparam logic [12:0] IORD = 13'h0400;
    localparam logic [12:0] PCS  = 13'h0200;
    localparam logic [12:0] R2L  = 13'h0100;
    localparam logic [12:0] SRCA = 13'h0080;
    localparam logic [12:0] M2R  = 13'h0040;
    localparam logic [12:0] RW   = 13'h0020;
    localparam logic [12:0] MRD  = 13'h0010;
    localparam logic [12:0] MWR  = 13'h0008;
    localparam logic [12:0] DONE = 13'h0004;
    localparam logic [12:0] ILL  = 13'h0002;
    localparam logic [12:0] MERR = 13'h0001;

    localparam logic [10:0] LDUR = 11'b11111000010;
    localparam logic [10:0] STUR = 11'b11111000000;
    localparam logic [10:0] ADD  = 11'b10001011000;
    localparam logic [10:0] ADDI = 11'b10010001000;
    localparam logic [10:0] CBZ  = 11'b10110100011;
    localparam logic [10:0] CBNZ = 11'b10110101000;
    localparam logic [10:0] BOP  = 11'b00010100011;
    localparam logic [10:0] BAD  = 11'b00000000000;

    logic        clk;
    logic        rst_w  [3];
    logic [10:0] op_w   [3];
    logic        zero_w [3];
    logic        rdy_w  [3];

    logic        pcw_w  [3];
    logic        irw_w  [3];
    logic        iord_w [3];
    logic        pcs_w  [3];
    logic        r2l_w  [3];
    logic        srca_w [3];
    logic        m2r_w  [3];
    logic        rw_w   [3];
    logic        mrd_w  [3];
    logic        mwr_w  [3];
    logic [1:0]  srcb_w [3];
    logic [1:0]  aop_w  [3];
    logic        done_w [3];
    logic        ill_w  [3];
    logic        merr_w [3];
    logic [3:0]  st_w   [3];

    int total;
    int bad;

    maindec_mc dut (
        .clk(clk), .reset(rst_w[0]), .Op(op_w[0]), .Zero(zero_w[0]), .mem_ready(rdy_w[0]),
        .PCWrite(pcw_w[0]), .IRWrite(irw_w[0]), .IorD(iord_w[0]), .PCSrc(pcs_w[0]),
        .Reg2Loc(r2l_w[0]), .ALUSrcA(srca_w[0]), .MemtoReg(m2r_w[0]), .RegWrite(rw_w[0]),
        .MemRead(mrd_w[0]), .MemWrite(mwr_w[0]), .ALUSrcB(srcb_w[0]), .ALUOp(aop_w[0]),
        .instr_done(done_w[0]), .illegal(ill_w[0]), .mem_err(merr_w[0]), .state(st_w[0])
    );

    maindec_mc #(.BR_EN(1'b0)) dut_nobr (
        .clk(clk), .reset(rst_w[1]), .Op(op_w[1]), .Zero(zero_w[1]), .mem_ready(rdy_w[1]),
        .PCWrite(pcw_w[1]), .IRWrite(irw_w[1]), .IorD(iord_w[1]), .PCSrc(pcs_w[1]),
        .Reg2Loc(r2l_w[1]), .ALUSrcA(srca_w[1]), .MemtoReg(m2r_w[1]), .RegWrite(rw_w[1]),
        .MemRead(mrd_w[1]), .MemWrite(mwr_w[1]), .ALUSrcB(srcb_w[1]), .ALUOp(aop_w[1]),
        .instr_done(done_w[1]), .illegal(ill_w[1]), .mem_err(merr_w[1]), .state(st_w[1])
    );

    maindec_mc #(.WAIT_MAX(4)) dut_w4 (
        .clk(clk), .reset(rst_w[2]), .Op(op_w[2]), .Zero(zero_w[2]), .mem_ready(rdy_w[2]),
        .PCWrite(pcw_w[2]), .IRWrite(irw_w[2]), .IorD(iord_w[2]), .PCSrc(pcs_w[2]),
        .Reg2Loc(r2l_w[2]), .ALUSrcA(srca_w[2]), .MemtoReg(m2r_w[2]), .RegWrite(rw_w[2]),
        .MemRead(mrd_w[2]), .MemWrite(mwr_w[2]), .ALUSrcB(srcb_w[2]), .ALUOp(aop_w[2]),
        .instr_done(done_w[2]), .illegal(ill_w[2]), .mem_err(merr_w[2]), .state(st_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [20:0] mk(input int st, input logic [1:0] aop,
                                       input logic [1:0] srcb, input logic [12:0] b);
        return {4'(st), aop, srcb, b};
    endfunction

    function automatic logic [20:0] obs(input int i);
        return {st_w[i], aop_w[i], srcb_w[i],
                pcw_w[i], irw_w[i], iord_w[i], pcs_w[i], r2l_w[i], srca_w[i], m2r_w[i],
                rw_w[i], mrd_w[i], mwr_w[i], done_w[i], ill_w[i], merr_w[i]};
    endfunction

    task automatic chk(input int i, input string tag, input logic [20:0] e);
        logic [20:0] o;
        o = obs(i);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Sample 1 time unit after inputs settle, then advance to the next falling edge.
    task automatic step(input int i, input string tag, input logic [20:0] e);
        #1;
        chk(i, tag, e);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [20:0] fetch_rdy;
        fetch_rdy = mk(0, 2'b00, 2'b01, MRD | IRW | PCW);
        total = 0;
        bad   = 0;
        for (int i = 0; i < 3; i++) begin
            rst_w[i]  = 1'b1;
            op_w[i]   = LDUR;
            zero_w[i] = 1'b0;
            rdy_w[i]  = 1'b1;
        end
        @(negedge clk);

        // Reset held three cycles: everything low.
        step(0, "rst_c0", '0);
        step(0, "rst_c1", '0);
        step(0, "rst_c2", '0);
        rst_w[0] = 1'b0;

        // LDUR: 0,1,2,3,4.
        step(0, "ld_fetch", fetch_rdy);
        step(0, "ld_dec",   mk(1, 2'b00, 2'b11, '0));
        step(0, "ld_adr",   mk(2, 2'b00, 2'b10, SRCA));
        step(0, "ld_rd",    mk(3, 2'b00, 2'b00, IORD | MRD));
        step(0, "ld_wb",    mk(4, 2'b00, 2'b00, RW | M2R | DONE));

        // ADD with two stalled fetch cycles.
        op_w[0]  = ADD;
        rdy_w[0] = 1'b0;
        step(0, "add_fwait0", mk(0, 2'b00, 2'b01, MRD));
        step(0, "add_fwait1", mk(0, 2'b00, 2'b01, MRD));
        rdy_w[0] = 1'b1;
        step(0, "add_fetch", fetch_rdy);
        step(0, "add_dec",   mk(1, 2'b00, 2'b11, '0));
        step(0, "add_exec",  mk(6, 2'b10, 2'b00, SRCA));
        step(0, "add_wb",    mk(8, 2'b00, 2'b00, RW | DONE));

        // CBNZ, Zero=0: branch taken.
        op_w[0]   = CBNZ;
        zero_w[0] = 1'b0;
        step(0, "cbnz0_fetch", fetch_rdy);
        step(0, "cbnz0_dec",   mk(1, 2'b00, 2'b11, R2L));
        step(0, "cbnz0_cbr",   mk(9, 2'b01, 2'b00, SRCA | R2L | PCS | PCW | DONE));

        // CBNZ, Zero=1: not taken.
        zero_w[0] = 1'b1;
        step(0, "cbnz1_fetch", fetch_rdy);
        step(0, "cbnz1_dec",   mk(1, 2'b00, 2'b11, R2L));
        step(0, "cbnz1_cbr",   mk(9, 2'b01, 2'b00, SRCA | R2L | PCS | DONE));

        // CBZ, Zero=1: taken, branch sense relatched.
        op_w[0] = CBZ;
        step(0, "cbz1_fetch", fetch_rdy);
        step(0, "cbz1_dec",   mk(1, 2'b00, 2'b11, R2L));
        step(0, "cbz1_cbr",   mk(9, 2'b01, 2'b00, SRCA | R2L | PCS | PCW | DONE));

        // Unconditional branch.
        op_w[0]   = BOP;
        zero_w[0] = 1'b0;
        step(0, "b_fetch", fetch_rdy);
        step(0, "b_dec",   mk(1, 2'b00, 2'b11, '0));
        step(0, "b_ubr",   mk(10, 2'b00, 2'b00, PCS | PCW | DONE));

        // Unsupported opcode.
        op_w[0] = BAD;
        step(0, "bad_fetch", fetch_rdy);
        step(0, "bad_dec",   mk(1, 2'b00, 2'b11, ILL | DONE));

        // STUR with three stalled write cycles.
        op_w[0] = STUR;
        step(0, "st_fetch", fetch_rdy);
        step(0, "st_dec",   mk(1, 2'b00, 2'b11, R2L));
        step(0, "st_adr",   mk(2, 2'b00, 2'b10, SRCA));
        rdy_w[0] = 1'b0;
        step(0, "st_wr_w0", mk(5, 2'b00, 2'b00, IORD | MWR | R2L));
        step(0, "st_wr_w1", mk(5, 2'b00, 2'b00, IORD | MWR | R2L));
        step(0, "st_wr_w2", mk(5, 2'b00, 2'b00, IORD | MWR | R2L));
        rdy_w[0] = 1'b1;
        step(0, "st_wr_ok", mk(5, 2'b00, 2'b00, IORD | MWR | R2L | DONE));

        // ADDI, then reset in IMMEX aborts it.
        op_w[0] = ADDI;
        step(0, "addi_fetch", fetch_rdy);
        step(0, "addi_dec",   mk(1, 2'b00, 2'b11, '0));
        #1;
        chk(0, "addi_immex", mk(7, 2'b10, 2'b10, SRCA));
        rst_w[0] = 1'b1;
        #1;
        chk(0, "addi_rst", '0);
        @(negedge clk);
        rst_w[0] = 1'b0;
        step(0, "addi_after_rst", fetch_rdy);

        // BR_EN=0: CBNZ is illegal.
        op_w[1]  = CBNZ;
        rst_w[1] = 1'b0;
        step(1, "nobr_fetch", fetch_rdy);
        step(1, "nobr_dec",   mk(1, 2'b00, 2'b11, R2L | ILL | DONE));
        step(1, "nobr_back",  fetch_rdy);

        // WAIT_MAX=4: fetch timeout after four stalled cycles.
        rdy_w[2] = 1'b0;
        rst_w[2] = 1'b0;
        step(2, "to_w1",    mk(0, 2'b00, 2'b01, MRD));
        step(2, "to_w2",    mk(0, 2'b00, 2'b01, MRD));
        step(2, "to_w3",    mk(0, 2'b00, 2'b01, MRD));
        step(2, "to_err",   mk(0, 2'b00, 2'b01, MRD | MERR));
        step(2, "to_retry", mk(0, 2'b00, 2'b01, MRD));
        rdy_w[2] = 1'b1;
        step(2, "to_fetch", fetch_rdy);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
